// File: rtl/secded_mem_sequencer_if.sv
// Control and memory-port bundle between the SECDED sequencer and its data memory.
// master is the sequencer side; slave is the memory/host side.
interface secded_mem_sequencer_if #(
  parameter int AW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data;
  logic [3:0]    err1_cnt;
  logic [3:0]    err2_cnt;

  modport master (
    input  start, mem_rd_data,
    output busy, done, mem_addr, mem_wr_en, mem_wr_data, err1_cnt, err2_cnt
  );

  modport slave (
    output start, mem_rd_data,
    input  busy, done, mem_addr, mem_wr_en, mem_wr_data, err1_cnt, err2_cnt
  );
endinterface

// File: rtl/secded_mem_sequencer.sv
// Walks NUM_MSG Hamming SECDED codewords in memory, corrects single errors, flags
// double errors, and writes an 11-bit result plus two flag bits back per message.
module secded_mem_sequencer #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  secded_mem_sequencer_if.master bus
);

  localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, NEXT, FIN
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [7:0]    lo_reg, lo_next;
  logic [7:0]    hi_reg, hi_next;
  logic [15:0]   result_reg, result_next;
  logic [3:0]    err1_reg, err1_next;
  logic [3:0]    err2_reg, err2_next;
  logic          done_reg, done_next;

  logic [AW-1:0] addr_c;
  logic          wr_en_c;
  logic [7:0]    wr_data_c;

  // ---------------- decode datapath ----------------
  logic [15:0] cw;
  logic [3:0]  syn_term [1:15];
  logic [3:0]  syndrome;
  logic        parity;
  logic [10:0] data_fix;
  logic [15:0] decoded;

  assign cw     = {hi_reg, lo_reg};
  assign parity = ^cw;

  // Each set bit contributes its own position to the syndrome.
  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_syn
      assign syn_term[gi] = cw[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  always_comb begin
    syndrome = 4'd0;
    for (int k = 1; k < 16; k++) begin
      syndrome = syndrome ^ syn_term[k];
    end
  end

  // Data bit d(gi+1) lives at the gi-th non-power-of-two position; a flip is only
  // applied when overall parity says exactly one bit is wrong.
  generate
    for (gi = 0; gi < 11; gi++) begin : g_data
      localparam int POS = (gi == 0) ? 3 : ((gi < 4) ? gi + 4 : gi + 5);
      assign data_fix[gi] = cw[POS] ^ (parity && (syndrome == 4'(POS)));
    end
  endgenerate

  always_comb begin
    if (parity) begin
      decoded = {5'b01000, data_fix};
    end else if (syndrome != 4'd0) begin
      decoded = {5'b10000, data_fix};
    end else begin
      decoded = {5'b00000, data_fix};
    end
  end

  // ---------------- address generation ----------------
  logic [AW-1:0] src_addr, dst_addr;
  assign src_addr = AW'(SRC_BASE + 2 * int'(idx_reg));
  assign dst_addr = AW'(DST_BASE + 2 * int'(idx_reg));

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      lo_reg     <= 8'd0;
      hi_reg     <= 8'd0;
      result_reg <= 16'd0;
      err1_reg   <= 4'd0;
      err2_reg   <= 4'd0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      lo_reg     <= lo_next;
      hi_reg     <= hi_next;
      result_reg <= result_next;
      err1_reg   <= err1_next;
      err2_reg   <= err2_next;
      done_reg   <= done_next;
    end
  end

  // ---------------- next state / outputs ----------------
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    lo_next     = lo_reg;
    hi_next     = hi_reg;
    result_next = result_reg;
    err1_next   = err1_reg;
    err2_next   = err2_reg;
    done_next   = done_reg;
    addr_c      = '0;
    wr_en_c     = 1'b0;
    wr_data_c   = 8'd0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          idx_next   = '0;
          err1_next  = 4'd0;
          err2_next  = 4'd0;
          done_next  = 1'b0;
          state_next = RD_LO;
        end
      end
      RD_LO: begin
        addr_c     = src_addr;
        state_next = RD_HI;
      end
      RD_HI: begin
        // Read data returned here belongs to the address issued in RD_LO.
        addr_c     = src_addr + AW'(1);
        lo_next    = bus.mem_rd_data;
        state_next = CAP_HI;
      end
      CAP_HI: begin
        hi_next    = bus.mem_rd_data;
        state_next = DECODE;
      end
      DECODE: begin
        result_next = decoded;
        if (parity) begin
          err1_next = (err1_reg == 4'hF) ? err1_reg : err1_reg + 4'd1;
        end else if (syndrome != 4'd0) begin
          err2_next = (err2_reg == 4'hF) ? err2_reg : err2_reg + 4'd1;
        end
        state_next = WR_LO;
      end
      WR_LO: begin
        addr_c     = dst_addr;
        wr_en_c    = 1'b1;
        wr_data_c  = result_reg[7:0];
        state_next = WR_HI;
      end
      WR_HI: begin
        addr_c     = dst_addr + AW'(1);
        wr_en_c    = 1'b1;
        wr_data_c  = result_reg[15:8];
        state_next = NEXT;
      end
      NEXT: begin
        if (idx_reg == IW'(NUM_MSG - 1)) begin
          state_next = FIN;
        end else begin
          idx_next   = idx_reg + IW'(1);
          state_next = RD_LO;
        end
      end
      FIN: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_wr_en   = wr_en_c;
  assign bus.mem_wr_data = wr_data_c;
  assign bus.err1_cnt    = err1_reg;
  assign bus.err2_cnt    = err2_reg;

endmodule

// File: tb/tb_secded_mem_sequencer.sv
// Scoreboard bench: codewords are built by encoding random data and planting 0/1/2 bit
// errors; expected write-backs are queued and a negedge monitor checks every write.
module tb_secded_mem_sequencer;

  localparam int NUM = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  secded_mem_sequencer_if #(.AW(8)) bus ();

  secded_mem_sequencer #(
    .NUM_MSG(NUM), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, read-before-write.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    bus.mem_rd_data <= mem[bus.mem_addr];
    if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wr_data;
  end

  wr_t         exp_q [$];
  logic [15:0] exp_res [NUM];
  int          exp_e1;
  int          exp_e2;

  logic [15:0] dir_cw  [4] = '{16'hFFFF, 16'hFFFE, 16'h7FFF, 16'hFDF7};
  logic [15:0] dir_res [4] = '{16'h07FF, 16'h47FF, 16'h47FF, 16'h87EE};
  int          dir_kind[4] = '{0, 1, 1, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic        p;
    int          n;
    c = '0;
    n = 0;
    for (int j = 1; j < 16; j++) begin
      if ((j & (j - 1)) != 0) begin
        c[j] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int j = 1; j < 16; j++) begin
        if (((j >> k) & 1) == 1 && j != (1 << k)) p = p ^ c[j];
      end
      c[1 << k] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int          n;
    d = '0;
    n = 0;
    for (int j = 1; j < 16; j++) begin
      if ((j & (j - 1)) != 0) begin
        d[n] = c[j];
        n++;
      end
    end
    return d;
  endfunction

  // mode 0 places the four hand-picked codewords first; the rest are random.
  task automatic load_run(input int mode);
    logic [10:0] d;
    logic [15:0] c;
    int          kind;
    int          b1;
    int          b2;
    exp_e1 = 0;
    exp_e2 = 0;
    for (int k = 0; k < NUM; k++) begin
      if (mode == 0 && k < 4) begin
        c          = dir_cw[k];
        exp_res[k] = dir_res[k];
        kind       = dir_kind[k];
      end else begin
        d    = 11'($urandom);
        kind = int'($urandom_range(0, 2));
        c    = encode(d);
        b1   = int'($urandom_range(0, 15));
        b2   = b1;
        while (b2 == b1) b2 = int'($urandom_range(0, 15));
        if (kind >= 1) c[b1] = ~c[b1];
        if (kind == 2) c[b2] = ~c[b2];
        if (kind == 0)      exp_res[k] = {5'b00000, d};
        else if (kind == 1) exp_res[k] = {5'b01000, d};
        else                exp_res[k] = {5'b10000, extract(c)};
      end
      if (kind == 1) exp_e1++;
      if (kind == 2) exp_e2++;
      mem[SRC + 2 * k]     = c[7:0];
      mem[SRC + 2 * k + 1] = c[15:8];
      mem[DST + 2 * k]     = 8'h5A;
      mem[DST + 2 * k + 1] = 8'h5A;
    end
  endtask

  task automatic push_writes(input int n);
    wr_t w;
    for (int j = 0; j < n; j++) begin
      w.addr = 8'(DST + j);
      w.data = (j % 2 == 1) ? exp_res[j / 2][15:8] : exp_res[j / 2][7:0];
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Full run: start, poke start while busy, check done latency and final counters.
  task automatic do_run(input string tag);
    int cyc;
    pulse_start();
    check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
    cyc = 0;
    while (!bus.done && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
      bus.start = (cyc == 20) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    check({tag, "_done_cycle"}, 32'(cyc), 32'(7 * NUM + 1));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_err1_cnt"}, 32'(bus.err1_cnt), 32'(exp_e1));
    check({tag, "_err2_cnt"}, 32'(bus.err2_cnt), 32'(exp_e2));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    $display("run %s: cycles=%0d err1=%0d err2=%0d", tag, cyc, bus.err1_cnt, bus.err2_cnt);
  endtask

  // Monitor: every write the DUT performs must match the head of the queue.
  wr_t got;
  always @(negedge clk) begin
    if (!reset && bus.mem_wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required=no write",
                 bus.mem_addr, bus.mem_wr_data);
      end else begin
        got = exp_q.pop_front();
        $display("wr addr=%0d data=%h exp_addr=%0d exp_data=%h",
                 bus.mem_addr, bus.mem_wr_data, got.addr, got.data);
        check("wr_addr", 32'(bus.mem_addr), 32'(got.addr));
        check("wr_data", 32'(bus.mem_wr_data), 32'(got.data));
      end
    end
  end

  initial begin
    bit found;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    check("rst_err1", 32'(bus.err1_cnt), 32'd0);
    check("rst_err2", 32'(bus.err2_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1 check("idle_busy", 32'(bus.busy), 32'd0);

    // Directed codewords first, random tail.
    load_run(0);
    push_writes(2 * NUM);
    do_run("directed");
    check("dir0_lo", 32'(mem[DST + 0]), 32'h0FF);
    check("dir0_hi", 32'(mem[DST + 1]), 32'h007);
    check("dir3_lo", 32'(mem[DST + 6]), 32'h0EE);
    check("dir3_hi", 32'(mem[DST + 7]), 32'h087);

    for (int r = 0; r < 3; r++) begin
      load_run(1);
      push_writes(2 * NUM);
      do_run($sformatf("random%0d", r));
    end

    // Abort in WR_HI of message 4: only 9 writes may land.
    load_run(1);
    push_writes(9);
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en && bus.mem_addr == 8'(DST + 8)) found = 1'b1;
    end
    check("reach_msg4_wr_lo", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    check("msg4_wr_hi_addr", 32'(bus.mem_addr), 32'(DST + 9));
    reset = 1'b1;
    #1;
    check("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_err1", 32'(bus.err1_cnt), 32'd0);
    check("abort_err2", 32'(bus.err2_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_msg4_lo_kept", 32'(mem[DST + 8]), 32'(exp_res[4][7:0]));
    check("abort_msg4_hi_untouched", 32'(mem[DST + 9]), 32'h05A);
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;

    push_writes(2 * NUM);
    do_run("after_abort");
    check("rerun_msg4_hi", 32'(mem[DST + 9]), 32'(exp_res[4][15:8]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secded_mem_sequencer.md
Name: secded_mem_sequencer

Overview:
- Hardware sequencer for the program-2 Hamming SECDED decode task.
- Walks data memory over NUM_MSG 16-bit codewords stored as byte pairs, decodes and corrects each, then writes an 11-bit result plus error flags back to memory.
- Sits beside the data memory in topLevel and raises done when all messages are written.
- Owns the memory port only while busy is high.

Parameters:
- NUM_MSG, 15, number of codewords processed per run
- SRC_BASE, 30, byte address of first codeword low byte (high byte at +1)
- DST_BASE, 0, byte address of first result low byte (high byte at +1)
- AW, 8, memory address width

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse that begins a run; ignored while busy
- busy  out  1  high from the cycle after an accepted start until the cycle done rises
- done  out  1  level; high after the last write until the next accepted start or reset
- mem_addr  out  AW  byte address
- mem_wr_en  out  1  write strobe
- mem_wr_data  out  8  write byte
- mem_rd_data  in  8  read byte; synchronous memory, valid one cycle after mem_addr
- err1_cnt  out  4  count of single-error messages this run
- err2_cnt  out  4  count of double-error messages this run

Behaviour:
- Reset values:
  - busy=0, done=0, mem_wr_en=0.
  - mem_addr=0, mem_wr_data=0.
  - err1_cnt=0, err2_cnt=0.
  - FSM in IDLE, message index i=0.
- Codeword bit map, LSB first:
  - p0, p1, p2, d1, p4, d2, d3, d4, p8, d5..d11 (bits 0..15).
- FSM states: IDLE, RD_LO, RD_HI, CAP_HI, DECODE, WR_LO, WR_HI, NEXT, FIN.
  - IDLE: on start, clear i and both counters, done<=0, go to RD_LO.
  - RD_LO: mem_addr=SRC_BASE+2i.
  - RD_HI: mem_addr=SRC_BASE+2i+1; capture mem_rd_data as lo byte.
  - CAP_HI: capture mem_rd_data as hi byte.
  - DECODE: register the result word and update counters.
  - WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, data=result[7:0].
  - WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, data=result[15:8].
  - NEXT: if i==NUM_MSG-1 go to FIN, else i++ and go to RD_LO.
  - FIN: done<=1, busy<=0, go to IDLE.
- Timing: 7 cycles per message; done rises 7*NUM_MSG+1 cycles after the start edge (106 for default).
- Decode:
  - s = XOR of indices of all set bits 1..15 (4-bit syndrome).
  - P = XOR of all 16 bits.
  - P=0, s=0: no error; result={5'b00000, d11..d1}.
  - P=1: single error. Flip bit s (s=0 means p0; data unaffected). Result={5'b01000, corrected d11..d1}; err1_cnt++.
  - P=0, s!=0: double error. Result={5'b10000, uncorrected d11..d1}; err2_cnt++.
- Counters saturate at 15.
- start while busy: ignored; no restart.
- start in the same cycle done would be cleared: start wins and a new run begins.
- Reset mid-run: immediate abort, mem_wr_en drops asynchronously, no further writes. Results already written remain.
- mem_wr_en is high only in WR_LO and WR_HI; never two writes to one address per run.

Test Plan:
- Codeword 0xFFFF at SRC_BASE (lo 0xFF, hi 0xFF), NUM_MSG=1, start -> mem[0]=0xFF, mem[1]=0x07, err1=0, err2=0, done at cycle 8.
- 0xFFFE (p0 flipped) -> result 0x47FF, err1_cnt=1.
- 0x7FFF (bit 15 flipped) -> syndrome 15, corrected, result 0x47FF.
- 0xFDF7 (bits 3 and 9 flipped) -> result 0x87EE, err2_cnt=1.
- Default 15 messages mixing 0/1/2-error cases -> all 30 result bytes match the model, counters match, done at cycle 106; start pulsed while busy changes nothing.
- Assert reset during WR_HI of message 4 -> writes stop, done=0, counters 0; a fresh start reprocesses from message 0.
